// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, default widths and requester-id type for mem_arbiter.
package mem_arb_pkg;
   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
   typedef logic req_id_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between an instruction and a data cache,
// one transaction in flight, with a per-transaction timeout that completes the request with an error.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              rdy0,
   output logic              rdy1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rdy,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   state_t            state_q, state_d;
   req_id_t           win_q, win_d, last_q, last_d, gnt;
   logic              err_q, err_d, we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [7:0]        cnt_q, cnt_d;

   // last_q resets to 1 so port 0 wins the first tie
   assign gnt = (req0 && req1) ? ~last_q : req1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         win_q   <= 1'b0;
         last_q  <= 1'b1;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         last_q  <= last_d;
         err_q   <= err_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      last_d  = last_q;
      err_d   = err_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (req0 || req1) begin
            state_d = ISSUE;
            win_d   = gnt;
            we_d    = gnt ? we1 : we0;
            addr_d  = gnt ? addr1 : addr0;
            wdata_d = gnt ? wdata1 : wdata0;
            err_d   = 1'b0;
            cnt_d   = '0;
         end
         // a response on the final allowed cycle still wins over the timeout
         ISSUE: if (mem_rdy || cnt_q == 8'(TIMEOUT - 1)) begin
            state_d = DONE;
            last_d  = win_q;
            err_d   = !mem_rdy;
            rdata_d = (mem_rdy && !we_q) ? mem_rdata : rdata_q;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = state_q != IDLE;
      mem_req   = state_q == ISSUE;
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      rdy0      = state_q == DONE && !win_q;
      rdy1      = state_q == DONE && win_q;
      err0      = rdy0 && err_q;
      err1      = rdy1 && err_q;
      rdata     = rdata_q;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0, rst = 1'b0;
   logic          req0, req1, we0, we1, rdy0, rdy1, err0, err1;
   logic          mem_req, mem_we, mem_rdy, busy;
   logic [AW-1:0] addr0, addr1, mem_addr;
   logic [DW-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .rdy0(rdy0), .rdy1(rdy1), .err0(err0), .err1(err1), .rdata(rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .busy(busy)
   );

   int vectors = 0, miscompares = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: a granted request owns the memory port for up to TO cycles
   // (ending early on mem_rdy), then reports to its owner for one cycle.
   bit            m_inflight, m_complete, m_win, m_err, m_we;
   int            m_age;
   int            served[$];
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_inflight = 0;
         m_complete = 0;
         m_err      = 0;
         m_age      = 0;
         served.delete();
      end else if (m_complete) begin
         m_complete = 0;
      end else if (m_inflight) begin
         m_age++;
         if (mem_rdy || m_age == TO) begin
            m_inflight = 0;
            m_complete = 1;
            m_err      = !mem_rdy;
            served.push_back(int'(m_win));
            if (mem_rdy && !m_we) m_rdata = mem_rdata;
         end
      end else if (req0 || req1) begin
         m_win      = (req0 && req1) ? (served.size() != 0 && served[$] == 0) : req1;
         m_we       = m_win ? we1 : we0;
         m_addr     = m_win ? addr1 : addr0;
         m_wdata    = m_win ? wdata1 : wdata0;
         m_inflight = 1;
         m_age      = 0;
      end
   end

   initial forever begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(m_inflight || m_complete));
      check("mem_req", 32'(mem_req), 32'(m_inflight));
      check("rdy0", 32'(rdy0), 32'(m_complete && !m_win));
      check("rdy1", 32'(rdy1), 32'(m_complete && m_win));
      check("err0", 32'(err0), 32'(m_complete && !m_win && m_err));
      check("err1", 32'(err1), 32'(m_complete && m_win && m_err));
      if (m_inflight) begin
         check("mem_we", 32'(mem_we), 32'(m_we));
         check("mem_addr", mem_addr, m_addr);
         check("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_complete && !m_we) check("rdata", rdata, m_rdata);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit got[$];
      int n, n_rdy, n_err;
      {req0, req1, we0, we1, mem_rdy} = '0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_rdy", 32'({rdy0, rdy1, err0, err1}), 0);
      check("rst_rdata", rdata, 0);
      check("rst_mem_addr", mem_addr, 0);
      step();
      rst = 1'b1;
      // zero-wait read from port 0
      req0 = 1; we0 = 0; addr0 = 'h10; mem_rdy = 1; mem_rdata = 'hDEADBEEF;
      step();
      req0 = 0;
      @(negedge clk);
      check("zw_mem_req", 32'(mem_req), 1);
      check("zw_mem_addr", mem_addr, 'h10);
      check("zw_rdy0_early", 32'(rdy0), 0);
      step();
      mem_rdy = 0;
      @(negedge clk);
      check("zw_rdy0", 32'(rdy0), 1);
      check("zw_rdata", rdata, 'hDEADBEEF);
      check("zw_rdy1", 32'(rdy1), 0);
      // both ports held after reset: grants alternate starting with port 0
      rst = 0;
      step();
      rst = 1;
      req0 = 1; req1 = 1; addr0 = 'h1; addr1 = 'h2; mem_rdy = 1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (rdy0 || rdy1) got.push_back(rdy1);
      end
      step();
      req0 = 0; req1 = 0; mem_rdy = 0;
      check("rr_count", got.size(), 3);
      check("rr_g0", got.size() > 0 ? 32'(got[0]) : 32'hFFFF_FFFF, 0);
      check("rr_g1", got.size() > 1 ? 32'(got[1]) : 32'hFFFF_FFFF, 1);
      check("rr_g2", got.size() > 2 ? 32'(got[2]) : 32'hFFFF_FFFF, 0);
      repeat (2) step();
      // port 1 write with five wait cycles, request dropped mid-transaction
      req1 = 1; we1 = 1; addr1 = 'h20; wdata1 = 'h55AA;
      step();
      req1 = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("wr_mem_req", 32'(mem_req), 1);
         check("wr_addr", mem_addr, 'h20);
         check("wr_wdata", mem_wdata, 'h55AA);
         step();
      end
      mem_rdy = 1;
      step();
      mem_rdy = 0;
      n_rdy = 0; n_err = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rdy1) n_rdy++;
         if (err1) n_err++;
      end
      check("wr_rdy1_pulses", n_rdy, 1);
      check("wr_err1", n_err, 0);
      // port 0 read with memory never responding
      step();
      req0 = 1; we0 = 0; addr0 = 'h30;
      step();
      req0 = 0;
      n = 0; n_rdy = 0; n_err = 0;
      for (int i = 0; i < TO + 4; i++) begin
         @(negedge clk);
         if (mem_req) n++;
         if (rdy0) n_rdy++;
         if (rdy0 && err0) n_err++;
      end
      check("to_mem_req_cycles", n, TO);
      check("to_rdy0", n_rdy, 1);
      check("to_err0", n_err, 1);
      check("to_idle", 32'(busy), 0);
      // asynchronous reset in the middle of a transaction
      step();
      req0 = 1; addr0 = 'h40;
      step();
      #2 rst = 0;
      #1;
      check("ar_mem_req", 32'(mem_req), 0);
      check("ar_busy", 32'(busy), 0);
      step();
      rst = 1; mem_rdy = 1; mem_rdata = 'h1234;
      step();
      req0 = 0;
      @(negedge clk);
      check("ar_reissue", 32'(mem_req), 1);
      check("ar_addr", mem_addr, 'h40);
      step();
      mem_rdy = 0;
      @(negedge clk);
      check("ar_rdy0", 32'(rdy0), 1);
      check("ar_rdata", rdata, 'h1234);
      // randomized traffic against the model
      repeat (3000) begin
         step();
         req0 = $urandom_range(0, 2) != 0; req1 = $urandom_range(0, 2) != 0;
         we0 = $urandom_range(0, 1) != 0; we1 = $urandom_range(0, 1) != 0;
         addr0 = $urandom; addr1 = $urandom; wdata0 = $urandom; wdata1 = $urandom;
         mem_rdy = $urandom_range(0, 3) == 0; mem_rdata = $urandom;
      end
      step();
      {req0, req1, mem_rdy} = '0;
      repeat (TO + 4) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
